// File: rtl/sha3_block_packer.sv
// Packs 64-bit message words into one RATE_WORDS-word block for the Keccak core,
// applying single-word padding and the closing 0x80 bit. Optional build macro: MULTI_MSG_EN.
module sha3_block_packer #(
    parameter int RATE_WORDS = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               in,
    input  logic                      in_ready,
    input  logic                      is_last,
    input  logic [2:0]                byte_num,
    output logic                      buffer_full,
    output logic [64*RATE_WORDS-1:0]  out,
    output logic                      out_ready,
    input  logic                      f_ack
);

    localparam int CW = $clog2(RATE_WORDS + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RATE_WORDS);
    localparam logic [CW-1:0] LAST_CNT = CW'(RATE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_PAD    = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                    r_state;
    logic [CW-1:0]             r_count;
    logic [64*RATE_WORDS-1:0]  r_out;
    logic                      r_out_ready;
    logic                      r_buffer_full;

    state_t                    w_state_nxt;
    logic [CW-1:0]             w_count_nxt;
    logic [64*RATE_WORDS-1:0]  w_out_nxt;
    logic                      w_take;
    logic                      w_close;
    logic [63:0]               w_word;
    logic                      w_full;
    logic                      w_last_slot;

    // Valid bytes stay in the low lanes; a 0x01 marker byte sits directly above them.
    function automatic logic [63:0] pad_word(input logic [63:0] data, input logic [2:0] nbytes);
        logic [5:0]  sh;
        logic [63:0] marker;
        sh       = {nbytes, 3'b000};
        marker   = 64'h1 << sh;
        pad_word = (data & (marker - 64'h1)) | marker;
    endfunction

    assign w_full      = (r_count == FULL_CNT);
    assign w_last_slot = (r_count == LAST_CNT);

    // Next-state, word selection and block shift.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_out_nxt   = r_out;
        w_take      = 1'b0;
        w_close     = 1'b0;
        w_word      = 64'h0;
        case (r_state)
            ST_ACCEPT: begin
                if (w_full) begin
                    if (f_ack) begin
                        w_count_nxt = {CW{1'b0}};
                    end else begin
                        w_count_nxt = r_count;
                    end
                end else if (in_ready && !r_buffer_full) begin
                    w_take = 1'b1;
                    if (is_last) begin
                        w_word      = pad_word(in, byte_num);
                        w_close     = w_last_slot;
                        w_state_nxt = ST_PAD;
                    end else begin
                        w_word = in;
                    end
                end else begin
                    w_take = 1'b0;
                end
            end
            ST_PAD: begin
                if (w_full) begin
                    if (f_ack) begin
                        w_count_nxt = {CW{1'b0}};
`ifdef MULTI_MSG_EN
                        w_state_nxt = ST_ACCEPT;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end else begin
                        w_state_nxt = ST_PAD;
                    end
                end else begin
                    w_take  = 1'b1;
                    w_word  = 64'h0;
                    w_close = w_last_slot;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_ACCEPT;
            end
        endcase
        if (w_take) begin
            w_out_nxt   = {r_out[64*RATE_WORDS-65:0], w_word | {w_close, 63'h0}};
            w_count_nxt = r_count + CW'(1);
        end else begin
            w_out_nxt = r_out;
        end
    end

    // State registers; handshake outputs are registered from the next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_ACCEPT;
            r_count       <= {CW{1'b0}};
            r_out         <= {(64*RATE_WORDS){1'b0}};
            r_out_ready   <= 1'b0;
            r_buffer_full <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_out         <= w_out_nxt;
            r_out_ready   <= (w_count_nxt == FULL_CNT);
            r_buffer_full <= (w_count_nxt == FULL_CNT) || (w_state_nxt != ST_ACCEPT);
        end
    end

    assign out         = r_out;
    assign out_ready   = r_out_ready;
    assign buffer_full = r_buffer_full;

endmodule

// File: doc/sha3_block_packer.md
Name: sha3_block_packer

Overview:
- Collects 64-bit message words from the input stream into one rate-sized block for the Keccak permutation core.
- Pads the final partial word with the single-word padding rule: data bytes in the low lanes, then a 0x01 marker byte directly above them.
- Fills the rest of the block with zero words and sets the closing 0x80 bit.
- Sits between the host input interface and the permutation core; presents a full block with an out_ready/f_ack handshake.

Parameters:
RATE_WORDS, 9, block size in 64-bit words (9 = 576-bit rate); legal range 2..21.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in  input  64  message word; valid bytes in the low lanes
in_ready  input  1  upstream offers a word this cycle
is_last  input  1  qualifies in: final word of the message
byte_num  input  3  valid bytes in the final word (0..7); used only with is_last
buffer_full  output  1  stall to upstream: high when out_ready=1 or state≠ACCEPT
out  output  64*RATE_WORDS  assembled block; first word in the top 64 bits
out_ready  output  1  block complete and stable for the permutation core
f_ack  input  1  one-cycle pulse from the core: block consumed

Behaviour:
- Reset: out=0, word count=0, state=ACCEPT, out_ready=0, buffer_full=0. Reset overrides every other input in the same cycle, including mid-block and mid-pad.
- Word counter: width $clog2(RATE_WORDS+1); out_ready = (count==RATE_WORDS), registered.
- Shift rule: each accepted or generated word w updates out to {out[64*RATE_WORDS-65:0], w} and increments count.
- ACCEPT state:
  - A word is taken when in_ready && !buffer_full.
  - Not last: w = in.
  - is_last: w = padded word = {(8-byte_num)-byte field whose lowest byte is 0x01 and rest zero, in[8*byte_num-1:0]}. byte_num=0 gives w=64'h1.
  - After taking an is_last word, state goes to PAD.
- A message whose final word has 8 valid bytes is sent as a normal word, followed by an is_last word with byte_num=0.
- PAD state:
  - in_ready is ignored.
  - While count<RATE_WORDS, one zero word is generated per cycle.
- Closing bit: the word that brings count to RATE_WORDS during PAD, or the is_last word itself if it lands in the final slot, has bit 63 OR'd in. Example: byte_num=7 in the final slot gives top byte 0x81.
- Full block (count==RATE_WORDS):
  - No shifting; out is held.
  - f_ack clears count, so out_ready falls on the next cycle.
  - If the full block carried the padding, state goes to DONE on f_ack.
- f_ack while out_ready=0 is ignored.
- A word offered in the same cycle as f_ack is not taken (buffer_full is still high); it is taken on the following cycle.
- DONE: buffer_full=1 and no activity until reset.
- Latency: out_ready rises on the cycle after the RATE_WORDS-th word is shifted in. A padded block completes (RATE_WORDS - words already held) cycles after the is_last word is accepted.

Optional Feature:
MULTI_MSG_EN:
- Defined: after f_ack of a padded block, state returns to ACCEPT with count=0, so the next message can start without reset.
- Undefined: state goes to DONE as described above.

Test Plan (RATE_WORDS=9):
- Reset: hold reset for 2 cycles with in_ready=1 -> out=0, out_ready=0, buffer_full=0, no word accepted.
- Nine back-to-back words 64'h1..64'h9, is_last=0 -> out_ready=1 one cycle after the 9th accept; out[575:512]=64'h1, out[63:0]=64'h9; f_ack pulse -> out_ready=0 and buffer_full=0 on the next cycle.
- Single word in=64'h0000_0000_00AA_BBCC, is_last=1, byte_num=3:
  - Word0 = 64'h0000_0000_01AA_BBCC.
  - Eight zero words are generated; the last is 64'h8000_0000_0000_0000.
  - out_ready=1 nine cycles after the accept.
  - buffer_full=1 throughout PAD.
- Eight normal words, then is_last with byte_num=7 and in=64'h00FF_EEDD_CCBB_AA99 -> out[63:0]=64'h81FF_EEDD_CCBB_AA99 and no pad cycles. Without MULTI_MSG_EN, f_ack leads to DONE and further in_ready is ignored. With MULTI_MSG_EN, a new word is accepted on the cycle after f_ack.
- Full block with in_ready=1 and an f_ack pulse in the same cycle -> that word is not taken; it is taken on the next cycle as word 1 of the new block.
- Reset asserted on the 4th PAD cycle -> the next cycle shows all outputs at reset values and state=ACCEPT; a fresh message then pads correctly.
